seq_setup_module: RTL
=====================

# seq_setup_module

Consumer end of the `settings_if` / `controls_if` pair driven by the IDLE-state block. When enabled and `controls.ready` is seen, it latches mode, level and speed, then derives the sequence length and step period. It fills an internal colour buffer with an LFSR-generated Simon sequence and raises `o_done` for the game FSM. Downstream play/display blocks read the sequence through a registered read port.

## Interface
Parameters:
- `MAX_LEN`, 32: buffer depth; equals the Expert-level sequence length.
- `LFSR_SEED`, 16'hACE1: fixed seed; also replaces a zero seed.

Ports:
- `i_clk`  in  1  system clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `settings`  `settings_if.consumer`  —  reads `mode[1:0]`, `level[1:0]`, `speed[1:0]`.
- `controls`  `controls_if.consumer`  —  reads `ready` (1).
- `i_enable`  in  1  state enable from game FSM (active-high).
- `i_rd_addr`  in  5  sequence read index.
- `o_rd_color`  out  2  colour at `i_rd_addr`, registered.
- `o_seq_len`  out  6  latched sequence length (8..32).
- `o_period`  out  8  step period in 10 ms units.
- `o_mode`  out  2  latched mode, passed downstream.
- `o_active`  out  1  high in any state except IDLE.
- `o_done`  out  1  sequence ready.

## Operation
- States and transitions:
  - IDLE → CAPTURE when `i_enable && controls.ready` at a clock edge.
  - CAPTURE → FILL always.
  - FILL → DONE after the write at `idx == o_seq_len-1`.
  - DONE → IDLE when `i_enable` is low.
- `i_enable` low in CAPTURE or FILL: abort to IDLE on that edge, with `o_done` = 0. Latched outputs keep their values; buffer contents are undefined.
- `controls.ready` is ignored outside IDLE. A new run requires returning to IDLE first.
- CAPTURE latches and seeds:
  - `o_mode` ← `mode`.
  - Level to `o_seq_len`: 00→8, 01→16, 10→24, 11→32.
  - Speed to `o_period`: 00→100, 01→60, 10→35, 11→20.
  - LFSR seed: if `mode[0]` = 0, seed is `LFSR_SEED`.
  - If `mode[0]` = 1, seed is the free-running counter value. A zero counter value is replaced by `LFSR_SEED`.
- Free-running counter: 16 bits, reset to 0, increments every cycle, wraps at 0xFFFF→0.
- LFSR: 16-bit Galois, right shift, taps mask 0xB400.
  - Step: `lsb = lfsr[0]`; `lfsr = lfsr >> 1`; if `lsb`, `lfsr ^= 0xB400`.
- FILL, each cycle:
  - `mem[idx] ← lfsr[1:0]`, using the value before the step.
  - Step the LFSR.
  - `idx++`. `idx` is 6 bits and never exceeds `o_seq_len-1`.
- Read port: `o_rd_color ← mem[i_rd_addr]` every cycle, independent of state.
  - Addresses ≥ `o_seq_len` return stale or undefined data. The reader must not rely on it.
- Buffer is not reset. All control registers are reset.

## Timing
- Reset values: `o_rd_color` = 0, `o_seq_len` = 0, `o_period` = 0, `o_mode` = 0, `o_active` = 0, `o_done` = 0.
- Reset also clears state (IDLE), `idx`, LFSR (= `LFSR_SEED`) and the counter (0).
- Reset mid-run returns to IDLE immediately, asynchronously.
- Run latency, with trigger sampled at edge E0:
  - E0: state = CAPTURE; `o_active` = 1; latched outputs are valid after E0.
  - E0+1: state = FILL.
  - E0+2 … E0+1+L: the L buffer writes.
  - `o_done` = 1 after E0+1+L, so total latency is L+2 cycles.
- `o_done` stays high while in DONE. It falls on the edge where `i_enable` is sampled low; `o_active` falls on that same edge.
- Read latency: 1 cycle, address at edge N gives data after edge N.
- Same-edge cases:
  - Write to an address while reading it: the read returns the old data (read-before-write).
  - `i_enable` low together with the last FILL write: abort wins, state = IDLE, `o_done` = 0.

## Test plan
- Fixed seed:
  - Stimulus: reset, then `i_enable` = 1, `mode` = 00, `level` = 00, `speed` = 00, pulse `ready` one cycle.
  - Response: `o_done` rises exactly 10 cycles after the trigger edge.
  - `o_seq_len` = 8, `o_period` = 100.
  - Reading addresses 0..4 returns 1, 0, 0, 0, 2.
- Level/speed map:
  - Stimulus: run with `level` = 11, `speed` = 11.
  - Response: `o_seq_len` = 32, `o_period` = 20.
  - `o_done` appears after 34 cycles; all 32 addresses match a reference LFSR model.
- Abort:
  - Stimulus: drop `i_enable` at the 4th FILL cycle.
  - Response: next edge state = IDLE, `o_active` = 0, `o_done` never asserts.
  - A fresh trigger then completes normally.
- Random seed:
  - Stimulus: `mode` = 01, trigger at counter value 0x0000, then rerun at a known nonzero counter value.
  - Response: first run equals the fixed-seed sequence.
  - Second run matches the model seeded with that counter value; `o_mode` = 01.
- Ignore ready:
  - Stimulus: pulse `ready` during FILL and again during DONE.
  - Response: no restart, buffer unchanged, `o_done` held until `i_enable` falls.
- Async reset:
  - Stimulus: assert `i_rst` mid-FILL, between clock edges.
  - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_setup_module_if.sv
// seq_setup_module_if: settings and controls handshakes published by the IDLE-state block
interface settings_if;
  logic [1:0] mode;
  logic [1:0] level;
  logic [1:0] speed;
  modport producer (output mode, level, speed);
  modport consumer (input mode, level, speed);
endinterface

interface controls_if;
  logic ready;
  modport producer (output ready);
  modport consumer (input ready);
endinterface

// File: rtl/seq_setup_module.sv
// seq_setup_module: latches game settings and fills a colour buffer with an LFSR-generated Simon sequence
module seq_setup_module #(
  parameter int          MAX_LEN   = 32,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  settings_if.consumer        settings,
  controls_if.consumer        controls,
  input  logic                i_enable,
  input  logic [4:0]          i_rd_addr,
  output logic [1:0]          o_rd_color,
  output logic [5:0]          o_seq_len,
  output logic [7:0]          o_period,
  output logic [1:0]          o_mode,
  output logic                o_active,
  output logic                o_done
);
  typedef enum logic [1:0] {IDLE, CAPTURE, FILL, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] cnt, lfsr, lfsr_nx, seed;
  logic [5:0] idx;
  logic [1:0] mem [MAX_LEN];
  logic trig, wr, last;
  assign trig = state == IDLE && i_enable && controls.ready;
  assign wr = state == FILL && i_enable;
  assign last = idx == o_seq_len - 6'd1;
  assign o_active = state != IDLE;
  assign o_done = state == DONE;
  // a zero counter would lock the LFSR, so fall back to the fixed seed
  assign seed = settings.mode[0] && cnt != 16'd0 ? cnt : LFSR_SEED;
  always_comb begin
    state_nx = state;
    lfsr_nx = lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
    state_nx = state != IDLE && !i_enable ? IDLE :
               trig ? CAPTURE :
               state == CAPTURE ? FILL :
               state == FILL && last ? DONE : state;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= 16'd0;
      lfsr <= LFSR_SEED;
      idx <= 6'd0;
      o_seq_len <= 6'd0;
      o_period <= 8'd0;
      o_mode <= 2'd0;
      o_rd_color <= 2'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt + 16'd1;
      o_rd_color <= mem[i_rd_addr];
      if (trig) begin
        o_mode <= settings.mode;
        o_seq_len <= {1'b0, settings.level, 3'b000} + 6'd8;
        o_period <= settings.speed == 2'd0 ? 8'd100 :
                    settings.speed == 2'd1 ? 8'd60 :
                    settings.speed == 2'd2 ? 8'd35 : 8'd20;
        lfsr <= seed;
        idx <= 6'd0;
      end
      if (wr) begin
        lfsr <= lfsr_nx;
        idx <= last ? 6'd0 : idx + 6'd1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (wr) mem[idx[4:0]] <= lfsr[1:0];
  end
endmodule
